// File: rtl/adder_operand_sequencer.sv
// Operand sequencer wrapped around an external 4-bit ripple-carry adder: collects A/B nibbles,
// waits EVAL_CYCLES, captures {COUT,SUM}. Optional macro CARRY_CHAIN_EN feeds the last carry-out back as CIN.
module adder_operand_sequencer #(
    parameter int EVAL_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DIN,
    input  logic       DIN_CIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       CIN,
    input  logic [3:0] SUM_IN,
    input  logic       COUT_IN,
    output logic [4:0] RESULT,
    output logic       RESULT_VALID,
    input  logic       RESULT_READY,
    output logic [7:0] OP_COUNT
);
    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_EVAL   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_din_ready;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_cin;
    logic [3:0] r_eval_cnt;
    logic [4:0] r_result;
    logic       r_result_valid;
    logic [7:0] r_op_count;
    logic       w_din_hs;
    logic       w_res_hs;
    logic       w_eval_done;
    logic       w_cin_src;

    // Handshakes qualify on registered ready/valid so neither output depends on its partner input.
    always_comb begin
        w_next_state = r_state;
        w_din_hs     = DIN_VALID & r_din_ready;
        w_res_hs     = RESULT_READY & r_result_valid;
        w_eval_done  = (r_state == S_EVAL) && (r_eval_cnt == 4'd0);
        case (r_state)
            S_LOAD_A: begin
                if (w_din_hs) w_next_state = S_LOAD_B;
                else          w_next_state = S_LOAD_A;
            end
            S_LOAD_B: begin
                if (w_din_hs) w_next_state = S_EVAL;
                else          w_next_state = S_LOAD_B;
            end
            S_EVAL: begin
                if (w_eval_done) w_next_state = S_HOLD;
                else             w_next_state = S_EVAL;
            end
            S_HOLD: begin
                if (w_res_hs) w_next_state = S_LOAD_A;
                else          w_next_state = S_HOLD;
            end
            default: w_next_state = S_LOAD_A;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_LOAD_A;
        else     r_state <= w_next_state;
    end

`ifdef CARRY_CHAIN_EN
    logic r_chain;

    // Carry chain bit: last consumed carry-out becomes the next operation's carry-in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                r_chain <= 1'b0;
        else if (r_state == S_HOLD && w_res_hs) r_chain <= r_result[4];
        else                                    r_chain <= r_chain;
    end

    assign w_cin_src = r_chain;
`else
    assign w_cin_src = DIN_CIN;
`endif

    // Operand capture, settle counter, result capture and completion counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_din_ready    <= 1'b0;
            r_a            <= 4'd0;
            r_b            <= 4'd0;
            r_cin          <= 1'b0;
            r_eval_cnt     <= 4'd0;
            r_result       <= 5'd0;
            r_result_valid <= 1'b0;
            r_op_count     <= 8'd0;
        end else begin
            r_din_ready <= (w_next_state == S_LOAD_A) || (w_next_state == S_LOAD_B);
            if (r_state == S_LOAD_A && w_din_hs) r_a <= DIN;
            if (r_state == S_LOAD_B && w_din_hs) begin
                r_b        <= DIN;
                r_cin      <= w_cin_src;
                r_eval_cnt <= EVAL_LOAD;
            end else if (r_state == S_EVAL && r_eval_cnt != 4'd0) begin
                r_eval_cnt <= r_eval_cnt - 4'd1;
            end
            if (w_eval_done) begin
                r_result       <= {COUT_IN, SUM_IN};
                r_result_valid <= 1'b1;
            end else if (r_state == S_HOLD && w_res_hs) begin
                r_result_valid <= 1'b0;
                r_op_count     <= r_op_count + 8'd1;
            end
        end
    end

    assign DIN_READY    = r_din_ready;
    assign A            = r_a;
    assign B            = r_b;
    assign CIN          = r_cin;
    assign RESULT       = r_result;
    assign RESULT_VALID = r_result_valid;
    assign OP_COUNT     = r_op_count;
endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench: two sequencers (EVAL_CYCLES 1 and 3) each wrapped around a behavioural
// adder; sel picks which one receives stimulus and is observed.
module tb_adder_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'd0;
    logic       din_cin = 1'b0;
    logic       din_valid = 1'b0;
    logic       result_ready = 1'b0;
    logic       sel = 1'b0;

    logic       rdy1, cin1, rv1, cout1, rdy3, cin3, rv3, cout3;
    logic [3:0] a1, b1, sum1, a3, b3, sum3;
    logic [4:0] res1, res3;
    logic [7:0] cnt1, cnt3;

    logic       o_rdy, o_cin, o_rv;
    logic [3:0] o_a, o_b;
    logic [4:0] o_res;
    logic [7:0] o_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt [2];
    logic chain [2];

    always #5 clk = ~clk;

    assign {cout1, sum1} = 5'(a1) + 5'(b1) + 5'(cin1);
    assign {cout3, sum3} = 5'(a3) + 5'(b3) + 5'(cin3);

    adder_operand_sequencer #(.EVAL_CYCLES(1)) dut1 (
        .CLK(clk), .RST(rst), .DIN(din), .DIN_CIN(din_cin), .DIN_VALID(din_valid & ~sel),
        .DIN_READY(rdy1), .A(a1), .B(b1), .CIN(cin1), .SUM_IN(sum1), .COUT_IN(cout1),
        .RESULT(res1), .RESULT_VALID(rv1), .RESULT_READY(result_ready & ~sel), .OP_COUNT(cnt1));

    adder_operand_sequencer #(.EVAL_CYCLES(3)) dut3 (
        .CLK(clk), .RST(rst), .DIN(din), .DIN_CIN(din_cin), .DIN_VALID(din_valid & sel),
        .DIN_READY(rdy3), .A(a3), .B(b3), .CIN(cin3), .SUM_IN(sum3), .COUT_IN(cout3),
        .RESULT(res3), .RESULT_VALID(rv3), .RESULT_READY(result_ready & sel), .OP_COUNT(cnt3));

    assign o_rdy = sel ? rdy3 : rdy1;
    assign o_a   = sel ? a3   : a1;
    assign o_b   = sel ? b3   : b1;
    assign o_cin = sel ? cin3 : cin1;
    assign o_res = sel ? res3 : res1;
    assign o_rv  = sel ? rv3  : rv1;
    assign o_cnt = sel ? cnt3 : cnt1;

    // Asserts reset immediately (no edge needed), checks reset values, releases, checks ready.
    task automatic apply_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        result_ready = 1'b0;
        #1;
        checks++;
        if (o_rdy !== 1'b0 || o_a !== 4'd0 || o_b !== 4'd0 || o_cin !== 1'b0 ||
            o_res !== 5'd0 || o_rv !== 1'b0 || o_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_values got rdy=%b a=%0d b=%0d cin=%b res=%0d rv=%b cnt=%0d exp all 0",
                     o_rdy, o_a, o_b, o_cin, o_res, o_rv, o_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        chain[0] = 1'b0; chain[1] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_rdy !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", o_rdy);
        end
    endtask

    // One full operation on the selected DUT, checked against the arithmetic model.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input int gap, input int hold);
        int n;
        int idx;
        int ec;
        logic exp_cin;
        logic [4:0] exp_res;
        idx = sel ? 1 : 0;
        ec  = sel ? 3 : 1;
        n = 0;
        while (o_rdy !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL ready_timeout got=%b exp=1", o_rdy); end
        din = a; din_cin = ~c; din_valid = 1'b1;
        result_ready = (hold == 0);
        @(posedge clk); #1;
        din_valid = 1'b0;
        checks++;
        if (o_a !== a) begin failures++; $display("FAIL a_capture got=%0d exp=%0d", o_a, a); end
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o_rdy !== 1'b1) begin failures++; $display("FAIL wait_load_b ready got=%b exp=1", o_rdy); end
        end
`ifdef CARRY_CHAIN_EN
        exp_cin = chain[idx];
`else
        exp_cin = c;
`endif
        exp_res = 5'(a) + 5'(b) + 5'(exp_cin);
        din = b; din_cin = c; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        checks++;
        if (o_b !== b || o_cin !== exp_cin) begin
            failures++;
            $display("FAIL b_capture got b=%0d cin=%b exp b=%0d cin=%b", o_b, o_cin, b, exp_cin);
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (o_rv !== 1'b1 && n < 40);
        checks++;
        if (n != ec) begin failures++; $display("FAIL eval_latency got=%0d exp=%0d", n, ec); end
        checks++;
        if (o_res !== exp_res) begin failures++; $display("FAIL result got=%0d exp=%0d", o_res, exp_res); end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o_rv !== 1'b1 || o_res !== exp_res || o_rdy !== 1'b0) begin
                failures++;
                $display("FAIL hold_stall got rv=%b res=%0d rdy=%b exp rv=1 res=%0d rdy=0",
                         o_rv, o_res, o_rdy, exp_res);
            end
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt[idx] = (exp_cnt[idx] + 1) % 256;
        chain[idx] = exp_res[4];
        checks++;
        if (o_rv !== 1'b0 || o_rdy !== 1'b1) begin
            failures++;
            $display("FAIL consume got rv=%b rdy=%b exp rv=0 rdy=1", o_rv, o_rdy);
        end
        checks++;
        if (o_cnt !== 8'(exp_cnt[idx])) begin
            failures++;
            $display("FAIL op_count got=%0d exp=%0d", o_cnt, exp_cnt[idx]);
        end
        checks++;
        if (o_a !== a || o_b !== b || o_cin !== exp_cin) begin
            failures++;
            $display("FAIL operands_stable got a=%0d b=%0d cin=%b exp a=%0d b=%0d cin=%b",
                     o_a, o_b, o_cin, a, b, exp_cin);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
    endtask

    task automatic test_basic();
        sel = 1'b0;
        run_op(4'd3, 4'd5, 1'b0, 0, 0);
        run_op(4'd15, 4'd1, 1'b1, 0, 0);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3, 5);
        sel = 1'b1;
        run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3, 5);
    endtask

    task automatic test_eval3();
        sel = 1'b1;
        apply_reset();
        run_op(4'd7, 4'd9, 1'b0, 0, 0);
    endtask

    task automatic test_carry_chain();
        sel = 1'b1;
        apply_reset();
        run_op(4'd15, 4'd1, 1'b0, 0, 0);
        run_op(4'd0, 4'd0, 1'b0, 0, 0);
        checks++;
`ifdef CARRY_CHAIN_EN
        if (o_res !== 5'b00001) begin failures++; $display("FAIL chain_second got=%0d exp=1", o_res); end
`else
        if (o_res !== 5'b00000) begin failures++; $display("FAIL chain_second got=%0d exp=0", o_res); end
`endif
    endtask

    task automatic test_reset_mid_eval();
        sel = 1'b1;
        result_ready = 1'b0;
        din = 4'd6; din_valid = 1'b1;
        @(posedge clk); #1;
        din = 4'd4;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_a !== 4'd6 || o_b !== 4'd4 || o_rv !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_eval got a=%0d b=%0d rv=%b exp a=6 b=4 rv=0", o_a, o_b, o_rv);
        end
        apply_reset();
        run_op(4'd2, 4'd2, 1'b0, 0, 0);
        checks++;
        if (o_res !== 5'd4 || o_cnt !== 8'd1) begin
            failures++;
            $display("FAIL after_reset_op got res=%0d cnt=%0d exp res=4 cnt=1", o_res, o_cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            sel = 1'($urandom_range(0, 1));
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back_wrap();
        sel = 1'b0;
        apply_reset();
        for (int k = 0; k < 256; k++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, 0);
        end
        checks++;
        if (o_cnt !== 8'd0) begin failures++; $display("FAIL op_count_wrap got=%0d exp=0", o_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_eval3();
        test_carry_chain();
        test_reset_mid_eval();
        test_random();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
